// File: rtl/ej32_pkg.sv
// ej32 shared definitions used by the bytecode prefetch stage.
// Holds the IU address type, prefetch FIFO depth, ROM size and the
// prefetch FSM state encoding.
package ej32_pkg;

  // IU byte address type; the prefetch stage uses the same width.
  typedef logic [31:0] iu_addr_t;

  // Prefetch byte FIFO depth (power of 2, at least 4).
  localparam int PF_DEPTH = 8;

  // eForth image size in bytes; fetch addresses wrap modulo this.
  localparam int PF_ROM_SZ = 8192;

  // Prefetch fetch-engine states.
  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_FILL = 2'd1,
    PF_HOLD = 2'd2
  } pf_st_t;

endpackage

// File: rtl/ej32_pf_fifo.sv
// Byte FIFO for the prefetch stage.
// Single write port at the tail, multi-byte pop (0..4) at the head, and a
// 4-byte big-endian peek window. Bytes beyond the current count read as 0.
// A flush clears pointers and count in one edge.
module ej32_pf_fifo
  import ej32_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [7:0]             wr_d,
  input  logic [2:0]             pop_n,
  output logic [$clog2(DEPTH):0] cnt,
  output logic [$clog2(DEPTH):0] cnt_next,
  output logic [31:0]            win
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Pointer/count next state; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    cnt_d    = cnt_q - CW'(pop_n) + CW'(wr_en);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Byte storage; contents need no reset because the window masks by count.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_q[wr_ptr_q] <= wr_d;
    end
  end

  // Peek window: byte gi is the gi-th oldest entry, or 0 if not present.
  for (genvar gi = 0; gi < 4; gi++) begin : g_win
    logic [PW-1:0] idx;
    assign idx = rd_ptr_q + PW'(gi);
    assign win[31-8*gi -: 8] = (CW'(gi) < cnt_q) ? mem_q[idx] : 8'h00;
  end

  assign cnt      = cnt_q;
  assign cnt_next = cnt_d;

endmodule

// File: rtl/ej32_prefetch.sv
// ej32 bytecode prefetch stage.
// Drives the synchronous ROM address, captures the returned byte one cycle
// later into a byte FIFO and offers a 4-byte peek window to decode.
// Redirects flush the FIFO and drop any read still in flight.
// Optional: define EJ32_PF_STALL_CNT_EN to add a saturating 16-bit count of
// cycles in which the consumer asked for bytes but was refused.
module ej32_prefetch
  import ej32_pkg::*;
#(
  parameter int DEPTH  = PF_DEPTH,
  parameter int ASZ    = $bits(iu_addr_t),
  parameter int ROM_SZ = PF_ROM_SZ
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jmp,
  input  logic [ASZ-1:0]         jmp_a,
  output logic [ASZ-1:0]         rom_a,
  input  logic [7:0]             rom_d,
  input  logic [2:0]             req_n,
  output logic                   ack,
  output logic [31:0]            q_w,
  output logic [$clog2(DEPTH):0] q_cnt,
  output logic [ASZ-1:0]         pc
`ifdef EJ32_PF_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ASZ-1:0] AMASK = ASZ'(ROM_SZ - 1);

  pf_st_t         state_q, state_d;
  logic [ASZ-1:0] rom_a_q, pc_q;
  logic           inflight_q;
  logic           issue;
  logic           fill;
  logic           space_d;
  logic [2:0]     pop_n;
  logic [CW-1:0]  cnt, cnt_next;

  // HOLD means the FIFO plus the in-flight read already fill DEPTH, so the
  // state register doubles as the registered space check. IDLE only lasts
  // one cycle after reset with an empty FIFO, so it issues like FILL.
  assign issue = (state_q != PF_HOLD) && !jmp;

  // Returned byte is kept unless a redirect discards it.
  assign fill = inflight_q && !jmp;

  // Combinational pop handshake; redirect wins over a same-cycle pop.
  assign ack   = (req_n != 3'd0) && (32'(req_n) <= 32'(cnt)) && !jmp;
  assign pop_n = ack ? req_n : 3'd0;

  // Room for another read once this edge's pop, fill and issue settle.
  assign space_d = (32'(cnt_next) + 32'(issue)) < 32'(DEPTH);

  // Next-state logic: leave IDLE at once, toggle FILL/HOLD on space,
  // and always restart filling on a redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PF_IDLE: state_d = PF_FILL;
      PF_FILL: state_d = space_d ? PF_FILL : PF_HOLD;
      PF_HOLD: state_d = space_d ? PF_FILL : PF_HOLD;
      default: state_d = PF_IDLE;
    endcase
    if (jmp) begin
      state_d = PF_FILL;
    end
  end

  // FSM, fetch address, byte-0 address and in-flight flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PF_IDLE;
      rom_a_q    <= '0;
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (jmp) begin
        rom_a_q <= jmp_a & AMASK;
        pc_q    <= jmp_a & AMASK;
      end else begin
        if (issue) begin
          rom_a_q <= (rom_a_q + ASZ'(1)) & AMASK;
        end
        if (ack) begin
          pc_q <= (pc_q + ASZ'(req_n)) & AMASK;
        end
      end
    end
  end

  ej32_pf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (jmp),
    .wr_en    (fill),
    .wr_d     (rom_d),
    .pop_n    (pop_n),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .win      (q_w)
  );

  assign rom_a = rom_a_q;
  assign pc    = pc_q;
  assign q_cnt = cnt;

  // The peek window is 4 bytes wide, so larger requests are a consumer bug.
  assert property (@(posedge clk) disable iff (!rst) req_n <= 3'd4);

`ifdef EJ32_PF_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count refused requests, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if ((req_n != 3'd0) && !ack && !jmp && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ej32_prefetch.sv
// Self-checking bench for ej32_prefetch (DEPTH=8, ROM_SZ=8192).
module tb_ej32_prefetch;

  localparam int MASK = 8191;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_a = 32'h0;
  logic [31:0] rom_a;
  logic [7:0]  rom_d;
  logic [2:0]  req_n = 3'd0;
  logic        ack;
  logic [31:0] q_w;
  logic [3:0]  q_cnt;
  logic [31:0] pc;
`ifdef EJ32_PF_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [7:0] rom_mem [8192];

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  int          m_cnt, m_inf, m_stall;
  logic [31:0] m_pc, m_ra;

  typedef struct {
    int          n;
    logic [31:0] pc;
    logic [31:0] bytes;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  req;
    logic        ack;
    int          cnt;
    logic [31:0] pc;
    logic [31:0] ra;
    logic [31:0] w;
  } vec_t;
  vec_t vt[14];

  ej32_prefetch dut (
    .clk   (clk),
    .rst   (rst),
    .jmp   (jmp),
    .jmp_a (jmp_a),
    .rom_a (rom_a),
    .rom_d (rom_d),
    .req_n (req_n),
    .ack   (ack),
    .q_w   (q_w),
    .q_cnt (q_cnt),
    .pc    (pc)
`ifdef EJ32_PF_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for rom_a appears the cycle after.
  always @(posedge clk) rom_d <= rom_mem[rom_a[12:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_win();
    logic [31:0] w;
    logic [12:0] ix;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ix = 13'(m_pc + 32'(i));
      w = {w[23:0], (i < m_cnt) ? rom_mem[ix] : 8'h00};
    end
    return w;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_inf = 0; m_stall = 0; m_pc = 32'h0; m_ra = 32'h0;
    sb_q.delete();
  endtask

  // Apply inputs (called just after a negedge) and check outputs mid-cycle.
  task automatic drive(input logic [2:0] r, input logic j, input logic [31:0] ja);
    sb_t  e;
    logic exp_ack;
    req_n = r; jmp = j; jmp_a = ja;
    exp_ack = (r != 3'd0) && (int'(r) <= m_cnt) && !j;
    if (exp_ack) begin
      e.n = int'(r);
      e.pc = m_pc;
      e.bytes = model_win() >> (8 * (4 - int'(r)));
      sb_q.push_back(e);
    end
    #2;
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("q_cnt", 32'(q_cnt), 32'(m_cnt));
    chk("pc", pc, m_pc);
    chk("rom_a", rom_a, m_ra);
    chk("q_w", q_w, model_win());
`ifdef EJ32_PF_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (ack) begin
      if (sb_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL pop_unexpected at %0t: ack=1 req_n=%0d, no pop queued", $time, req_n);
      end else begin
        e = sb_q.pop_front();
        chk("pop_bytes", q_w >> (8 * (4 - e.n)), e.bytes);
        chk("pop_pc", pc, e.pc);
      end
    end else if (sb_q.size() != 0) begin
      chk("pop_missing", 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  // Clock edge: advance reference state with the inputs held this cycle.
  task automatic adv();
    logic a;
    int   iss;
    @(posedge clk);
    a = (req_n != 3'd0) && (int'(req_n) <= m_cnt) && !jmp;
    if ((req_n != 3'd0) && !a && !jmp && (m_stall != 65535)) m_stall++;
    if (jmp) begin
      m_cnt = 0; m_inf = 0;
      m_pc = jmp_a & MASK; m_ra = jmp_a & MASK;
    end else begin
      iss = (m_cnt + m_inf < 8) ? 1 : 0;
      if (a) begin
        m_cnt = m_cnt - int'(req_n);
        m_pc = (m_pc + 32'(req_n)) & MASK;
      end
      m_cnt = m_cnt + m_inf;
      m_inf = iss;
      if (iss != 0) m_ra = (m_ra + 32'd1) & MASK;
    end
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_rom_a"}, rom_a, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_q_cnt"}, 32'(q_cnt), 32'h0);
    chk({tag, "_ack"}, 32'(ack), 32'h0);
    chk({tag, "_q_w"}, q_w, 32'h0);
`ifdef EJ32_PF_STALL_CNT_EN
    chk({tag, "_stall"}, 32'(stall_cnt), 32'h0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    rom_mem[0] = 8'h10; rom_mem[1] = 8'h20; rom_mem[2] = 8'h30; rom_mem[3] = 8'h40;

    // Reset, fill, pop 3 at q_cnt=4, then fill to full (held until DEPTH).
    vt[0]  = '{3'd0, 1'b0, 0, 32'd0, 32'd0,  32'h00000000};
    vt[1]  = '{3'd0, 1'b0, 0, 32'd0, 32'd1,  32'h00000000};
    vt[2]  = '{3'd0, 1'b0, 1, 32'd0, 32'd2,  32'h10000000};
    vt[3]  = '{3'd0, 1'b0, 2, 32'd0, 32'd3,  32'h10200000};
    vt[4]  = '{3'd0, 1'b0, 3, 32'd0, 32'd4,  32'h10203000};
    vt[5]  = '{3'd3, 1'b1, 4, 32'd0, 32'd5,  32'h10203040};
    vt[6]  = '{3'd0, 1'b0, 2, 32'd3, 32'd6,  32'h40A10000};
    vt[7]  = '{3'd0, 1'b0, 3, 32'd3, 32'd7,  32'h40A1A000};
    vt[8]  = '{3'd0, 1'b0, 4, 32'd3, 32'd8,  32'h40A1A0A3};
    vt[9]  = '{3'd0, 1'b0, 5, 32'd3, 32'd9,  32'h40A1A0A3};
    vt[10] = '{3'd0, 1'b0, 6, 32'd3, 32'd10, 32'h40A1A0A3};
    vt[11] = '{3'd0, 1'b0, 7, 32'd3, 32'd11, 32'h40A1A0A3};
    vt[12] = '{3'd0, 1'b0, 8, 32'd3, 32'd11, 32'h40A1A0A3};
    vt[13] = '{3'd0, 1'b0, 8, 32'd3, 32'd11, 32'h40A1A0A3};

    repeat (3) @(negedge clk);
    chk("reset_rom_a", rom_a, 32'h0);
    chk("reset_q_cnt", 32'(q_cnt), 32'h0);
    chk("reset_q_w", q_w, 32'h0);
    chk("reset_pc", pc, 32'h0);
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].req, 1'b0, 32'h0);
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d_q_cnt", i), 32'(q_cnt), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
      chk($sformatf("vec%0d_rom_a", i), rom_a, vt[i].ra);
      chk($sformatf("vec%0d_q_w", i), q_w, vt[i].w);
      adv();
    end

    // Redirect with a same-cycle pop while full.
    drive(3'd1, 1'b1, 32'h100);
    chk("jmp_ack", 32'(ack), 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("jmp_q_cnt", 32'(q_cnt), 32'h0);
    chk("jmp_pc", pc, 32'h100);
    chk("jmp_rom_a", rom_a, 32'h100);
    chk("jmp_q_w", q_w, 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("jmp_no_stale", 32'(q_cnt), 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("jmp_byte0", 32'(q_w[31:24]), 32'hA5);
    chk("jmp_q_cnt1", 32'(q_cnt), 32'h1);
    adv();

    // Redirect while a read is in flight, to the top of ROM with upper bits set.
    drive(3'd0, 1'b1, 32'hFFFF_FFFE);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("wrap_rom_a0", rom_a, 32'd8190);
    chk("wrap_pc0", pc, 32'd8190);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("wrap_rom_a1", rom_a, 32'd8191);
    chk("wrap_stale_drop", 32'(q_cnt), 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("wrap_rom_a2", rom_a, 32'd0);
    chk("wrap_q_w1", q_w, 32'h5B000000);
    adv();
    drive(3'd2, 1'b0, 32'h0);
    chk("wrap_ack", 32'(ack), 32'h1);
    chk("wrap_q_w2", q_w, 32'h5B5A0000);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_byte0", 32'(q_w[31:24]), 32'h10);
    chk("wrap_q_cnt", 32'(q_cnt), 32'h1);
    adv();

    // Random pops and occasional redirects against the reference.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0)
        drive(3'($urandom_range(0, 4)), 1'b1, $urandom());
      else
        drive(3'($urandom_range(0, 4)), 1'b0, 32'h0);
      adv();
    end

    // Asynchronous reset in the middle of a fill, between clock edges.
    drive(3'd0, 1'b1, 32'h40);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    adv();
    req_n = 3'd1;
    #3;
    chk("pre_rst_ack", 32'(ack), 32'h1);
    async_reset_check("rst1");
    req_n = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Refused 4-byte requests on a filling queue.
    for (int i = 0; i < 5; i++) begin
      drive(3'd4, 1'b0, 32'h0);
      adv();
    end
    drive(3'd0, 1'b0, 32'h0);
`ifdef EJ32_PF_STALL_CNT_EN
    chk("stall_5", 32'(stall_cnt), 32'd5);
`endif
    #3;
    async_reset_check("rst2");
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Fetch restarts at address 0 with no stale byte.
    drive(3'd0, 1'b0, 32'h0);
    chk("restart_rom_a0", rom_a, 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("restart_rom_a1", rom_a, 32'h1);
    chk("restart_empty", 32'(q_cnt), 32'h0);
    adv();
    drive(3'd0, 1'b0, 32'h0);
    chk("restart_q_w", q_w, 32'h10000000);
    adv();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
